sprite_ram_loader: RTL and testbench

- Writer side of the sprite RAM that the robot icon renderer reads.
- Accepts a byte stream (typically from the UART receiver) carrying one sprite frame.
- Unpacks the bytes into 12-bit pixels and writes them at the correct addresses in the 8-row × 3-column sprite sheet.
- Lets the team replace animation frames at run time without a new bitstream.

---
 rtl/sprite_ram_loader_pkg.sv | 30 +++
 rtl/loader_timeout_counter.sv | 30 +++
 rtl/sprite_ram_loader.sv | 120 ++++++++++++
 tb/tb_sprite_ram_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_ram_loader_pkg.sv
// Shared sprite-sheet layout for the sprite RAM writer (loader) and reader (renderer).
// Both sides must take addresses, sizes and colour constants from here.
package sprite_ram_loader_pkg;

  localparam int SPRITE_COLS    = 34;
  localparam int SPRITE_ROWS    = 34;
  localparam int MEM_COLS       = SPRITE_COLS * 3;
  localparam int FRAME_ROW_SIZE = MEM_COLS * SPRITE_ROWS;
  localparam int ADDR_WIDTH     = 15;
  localparam int PIXEL_W        = 12;

  localparam logic [PIXEL_W-1:0] COLOR_TRANSPARENT = 12'h000;
  localparam logic [PIXEL_W-1:0] COLOR_SUBSTITUTE  = 12'h001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_FIN
  } load_state_t;

  // Robot orientation (0..7) to sheet row; identity today, kept here so the renderer follows any change.
  localparam logic [2:0] ORIENT_ROW [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  function automatic logic [2:0] orient_frame_row(input logic [2:0] orient);
    return ORIENT_ROW[orient];
  endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Counts idle clocks while an upload is running; expire fires on the LIMIT-th idle clock.
module loader_timeout_counter
  import sprite_ram_loader_pkg::*;
#(
  parameter int LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign expire = run && !clear && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!run || clear) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sprite_ram_loader.sv
// Unpacks a byte stream (sync, header, hi/lo pixel byte pairs) into 12-bit pixels
// and writes one sprite frame into the shared 8x3 sprite sheet RAM.
module sprite_ram_loader
  import sprite_ram_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE         = 8'hA5,
  parameter int         TIMEOUT_CYCLES    = 1_000_000,
  parameter bit         REMAP_TRANSPARENT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [PIXEL_W-1:0]    ram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int XW = $clog2(SPRITE_COLS);
  localparam int YW = $clog2(SPRITE_ROWS);
  localparam logic [XW-1:0] X_LAST = XW'(SPRITE_COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SPRITE_ROWS - 1);

  function automatic logic [PIXEL_W-1:0] remap_pixel(input logic [PIXEL_W-1:0] pix);
    if (REMAP_TRANSPARENT && pix == COLOR_TRANSPARENT) return COLOR_SUBSTITUTE;
    return pix;
  endfunction

  load_state_t           state, state_next;
  logic                  xfer, expire, hdr_bad, sync_hit, ready_next, timer_run;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [3:0]            pix_hi;

  assign xfer      = in_valid & in_ready;
  assign hdr_bad   = in_data[7] | (in_data[1:0] == 2'd3);
  assign sync_hit  = (state == ST_IDLE) && xfer && (in_data == SYNC_BYTE);
  assign busy      = (state != ST_IDLE);
  assign timer_run = (state == ST_HDR) || (state == ST_PIX_HI) || (state == ST_PIX_LO);

  loader_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .run    (timer_run),
    .clear  (xfer),
    .expire (expire)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (sync_hit) state_next = ST_HDR;
      ST_HDR:    if (expire) state_next = ST_IDLE;
                 else if (xfer) state_next = hdr_bad ? ST_IDLE : ST_PIX_HI;
      ST_PIX_HI: if (expire) state_next = ST_IDLE;
                 else if (xfer) state_next = ST_PIX_LO;
      ST_PIX_LO: if (expire) state_next = ST_IDLE;
                 else if (xfer) state_next = (x == X_LAST && y == Y_LAST) ? ST_FIN : ST_PIX_HI;
      ST_FIN:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    ready_next = (state_next == ST_IDLE) || (state_next == ST_HDR) ||
                 (state_next == ST_PIX_HI) || (state_next == ST_PIX_LO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= ready_next;
      done     <= (state == ST_FIN);
      if (sync_hit) error <= 1'b0;
      else if (((state == ST_HDR) && xfer && hdr_bad) || expire) error <= 1'b1;
    end
  end

  // Per-frame base is the only multiply; per-pixel addressing walks row_base/x by addition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x         <= '0;
      y         <= '0;
      row_base  <= '0;
      pix_hi    <= '0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= 1'b0;
      if (state == ST_HDR && xfer && !hdr_bad) begin
        row_base <= ADDR_WIDTH'(in_data[6:4]) * ADDR_WIDTH'(FRAME_ROW_SIZE)
                  + ADDR_WIDTH'(in_data[1:0]) * ADDR_WIDTH'(SPRITE_COLS);
        x <= '0;
        y <= '0;
      end else if (state == ST_PIX_HI && xfer) begin
        pix_hi <= in_data[3:0];
      end else if (state == ST_PIX_LO && xfer) begin
        ram_we    <= 1'b1;
        ram_waddr <= row_base + ADDR_WIDTH'(x);
        ram_wdata <= remap_pixel({pix_hi, in_data});
        if (x == X_LAST) begin
          x        <= '0;
          y        <= y + YW'(1);
          row_base <= row_base + ADDR_WIDTH'(MEM_COLS);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed bench for sprite_ram_loader: full frame, addressing, bad header, remap, timeout, reset.
module tb_sprite_ram_loader;
  import sprite_ram_loader_pkg::*;

  localparam int TMO = 64;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [7:0]            in_data = 8'h00;
  logic                  in_valid = 1'b0;
  logic                  in_ready, ram_we, busy, done, error;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [11:0]           ram_wdata;
  logic                  in_ready_n, ram_we_n, busy_n, done_n, error_n;
  logic [ADDR_WIDTH-1:0] ram_waddr_n;
  logic [11:0]           ram_wdata_n;

  sprite_ram_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO), .REMAP_TRANSPARENT(1'b1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .error(error)
  );

  sprite_ram_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO), .REMAP_TRANSPARENT(1'b0)) dut_noremap (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_n),
    .ram_we(ram_we_n), .ram_waddr(ram_waddr_n), .ram_wdata(ram_wdata_n),
    .busy(busy_n), .done(done_n), .error(error_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_count = 0;
  int          wr_cyc = 0;
  int          done_count = 0;
  int          done_cyc = 0;
  logic [14:0] addr_log [0:4095];
  logic [11:0] data_log [0:4095];
  logic [11:0] data_n_last;

  always @(negedge clk) begin
    if (ram_we) begin
      addr_log[wr_count] = ram_waddr;
      data_log[wr_count] = ram_wdata;
      wr_cyc = cyc;
      wr_count++;
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
    if (ram_we_n) data_n_last = ram_wdata_n;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) check("send_ready_wait", {31'd0, in_ready}, 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int b, d, nbad;

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_waddr", ram_waddr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);

    // Full frame at row 3, column 2, all 12'hFFF
    b = wr_count; d = done_count;
    send(8'hA5); send(8'h32);
    for (int i = 0; i < SPRITE_COLS * SPRITE_ROWS; i++) begin
      send(8'h0F); send(8'hFF);
    end
    idle(4);
    check("t1_writes", wr_count - b, 1156);
    check("t1_first_addr", addr_log[b], 10472);
    check("t1_last_addr", addr_log[b + 1155], 13871);
    nbad = 0;
    for (int i = 0; i < 1156; i++) if (data_log[b + i] !== 12'hFFF) nbad++;
    check("t1_data_fff", nbad, 0);
    check("t1_done_count", done_count - d, 1);
    check("t1_done_latency", done_cyc - wr_cyc, 1);
    check("t1_error", error, 0);
    check("t1_busy", busy, 0);

    // Row 7 column 0 addressing and row wrap
    b = wr_count;
    send(8'hA5); send(8'h70); send(8'h01); send(8'h23);
    idle(2);
    check("t2_first_addr", addr_log[b], 24276);
    check("t2_first_data", data_log[b], 12'h123);
    for (int i = 0; i < SPRITE_COLS; i++) begin
      send(8'h01); send(8'h23);
    end
    idle(2);
    check("t2_writes", wr_count - b, 35);
    check("t2_wrap_addr", addr_log[b + 34], 24378);
    idle(TMO + 10);
    check("t2_timeout_error", error, 1);
    check("t2_timeout_busy", busy, 0);

    // Bad frame select, then error clear by sync
    b = wr_count;
    send(8'hA5); idle(1);
    check("t3_sync_clears", error, 0);
    check("t3_busy_hdr", busy, 1);
    send(8'h03); idle(2);
    check("t3_bad_error", error, 1);
    check("t3_bad_busy", busy, 0);
    check("t3_no_write", wr_count - b, 0);
    send(8'hA5); idle(1);
    check("t3_resync_clear", error, 0);

    // Transparent remap (already in HDR), then reset during PIX_LO
    b = wr_count;
    send(8'h00); send(8'h00); send(8'h00);
    idle(2);
    check("t4_writes", wr_count - b, 1);
    check("t4_addr", addr_log[b], 0);
    check("t4_remap_data", data_log[b], 12'h001);
    check("t4_noremap_data", data_n_last, 12'h000);
    send(8'h00);
    #2 reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t6_in_ready", in_ready, 0);
    check("t6_ram_we", ram_we, 0);
    check("t6_waddr", ram_waddr, 0);
    check("t6_wdata", ram_wdata, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_error", error, 0);
    b = wr_count;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("t6_rel_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    check("t6_no_stray_write", wr_count - b, 0);
    check("t6_idle_busy", busy, 0);

    // Timeout after five pixels in row 1, column 1
    b = wr_count; d = done_count;
    send(8'hA5); send(8'h11);
    for (int i = 0; i < 5; i++) begin
      send(8'h0A); send(8'hBC);
    end
    idle(10);
    check("t5_busy_waiting", busy, 1);
    check("t5_error_waiting", error, 0);
    idle(TMO);
    check("t5_writes", wr_count - b, 5);
    check("t5_first_addr", addr_log[b], 3502);
    check("t5_last_addr", addr_log[b + 4], 3506);
    check("t5_data", data_log[b], 12'hABC);
    check("t5_error", error, 1);
    check("t5_busy", busy, 0);
    check("t5_no_done", done_count - d, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
